// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mem_ctrl_pkg : shared states, widths and types for the paged memory slave
// Revision     : 1.0
// ============================================================================
package mem_ctrl_pkg;

    localparam int PAGE_W    = 4;
    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 16;
    localparam int XFER_W    = 64;
    localparam int BURST_LEN = 4;

    typedef logic [PAGE_W-1:0]     page_t;
    typedef logic [MEM_ADDR_W-1:0] addr_t;
    typedef logic [MEM_DATA_W-1:0] word_t;
    typedef logic [XFER_W-1:0]     xfer_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_WAIT = 2'd2,
        READ    = 2'd3
    } state_t;

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// mem_array : single-port synchronous RAM, write enable, 1-cycle read latency
// Revision  : 1.0
// ============================================================================
module mem_array #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule : mem_array
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// mem_ctrl : paged bus slave moving 4-beat 16-bit bursts into a local RAM
// Options  : MEMCTRL_STATS_EN adds saturating completed-burst counters
// Revision : 1.0
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [3:0] PAGE   = 4'h2,
    parameter int         ADDR_W = 12,
    parameter int         DATA_W = 16
) (
    input  logic              clk,
    input  logic              resetH,
    input  logic              AddrValid,
    input  logic              rw,
    input  logic [DATA_W-1:0] AddrData_i,
    output logic [DATA_W-1:0] AddrData_o,
    output logic              AddrData_oe
`ifdef MEMCTRL_STATS_EN
    ,
    output logic [15:0]       wr_bursts,
    output logic [15:0]       rd_bursts
`endif
);

    state_t            r_state;
    logic [1:0]        r_beat;
    logic [ADDR_W-1:0] r_base;
    logic              r_oe;
    logic              w_page_hit;
    logic              w_last_beat;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_rdata;

    assign w_page_hit  = (AddrData_i[DATA_W-1 -: PAGE_W] == PAGE);
    assign w_last_beat = (r_beat == 2'(BURST_LEN - 1));

    // Reset blocks the in-flight write so an aborted beat never lands.
    // During READ the address runs one word ahead to prefetch the next beat.
    always_comb begin
        w_ram_we   = (r_state == WRITE) && !resetH;
        w_ram_addr = r_base + ADDR_W'(r_beat) + ADDR_W'(r_state == READ);
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (AddrData_i),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (resetH) begin
            r_state <= IDLE;
            r_beat  <= 2'd0;
            r_base  <= '0;
            r_oe    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (AddrValid && w_page_hit) begin
                        r_base  <= AddrData_i[ADDR_W-1:0];
                        r_beat  <= 2'd0;
                        r_state <= rw ? RD_WAIT : WRITE;
                    end
                end
                WRITE: begin
                    r_beat <= r_beat + 2'd1;
                    if (w_last_beat) begin
                        r_state <= IDLE;
                    end
                end
                RD_WAIT: begin
                    r_beat  <= 2'd0;
                    r_oe    <= 1'b1;
                    r_state <= READ;
                end
                READ: begin
                    r_beat <= r_beat + 2'd1;
                    if (w_last_beat) begin
                        r_oe    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // RAM read data is already registered; the registered enable gates it.
    assign AddrData_oe = r_oe;
    assign AddrData_o  = r_oe ? w_ram_rdata : '0;

`ifdef MEMCTRL_STATS_EN
    logic [15:0] r_wr_bursts;
    logic [15:0] r_rd_bursts;

    always_ff @(posedge clk) begin
        if (resetH) begin
            r_wr_bursts <= 16'h0;
            r_rd_bursts <= 16'h0;
        end else begin
            if (r_state == WRITE && w_last_beat && r_wr_bursts != 16'hFFFF) begin
                r_wr_bursts <= r_wr_bursts + 16'd1;
            end
            if (r_state == READ && w_last_beat && r_rd_bursts != 16'hFFFF) begin
                r_rd_bursts <= r_rd_bursts + 16'd1;
            end
        end
    end

    assign wr_bursts = r_wr_bursts;
    assign rd_bursts = r_rd_bursts;
`endif

endmodule : mem_ctrl
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_ctrl : scoreboard bench with a word-array reference model
// Revision    : 1.0
// ============================================================================
module tb_mem_ctrl;

    localparam logic [3:0] C_PAGE = 4'h2;

    logic        clk = 1'b0;
    logic        resetH;
    logic        AddrValid;
    logic        rw;
    logic [15:0] AddrData_i;
    logic [15:0] AddrData_o;
    logic        AddrData_oe;
`ifdef MEMCTRL_STATS_EN
    logic [15:0] wr_bursts;
    logic [15:0] rd_bursts;
`endif

    mem_ctrl #(
        .PAGE   (C_PAGE),
        .ADDR_W (12),
        .DATA_W (16)
    ) dut (
        .clk         (clk),
        .resetH      (resetH),
        .AddrValid   (AddrValid),
        .rw          (rw),
        .AddrData_i  (AddrData_i),
        .AddrData_o  (AddrData_o),
        .AddrData_oe (AddrData_oe)
`ifdef MEMCTRL_STATS_EN
        ,
        .wr_bursts   (wr_bursts),
        .rd_bursts   (rd_bursts)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: plain word array plus a written-yet flag.
    logic [15:0] model [4096];
    bit          known [4096];
    int          exp_wr = 0;
    int          exp_rd = 0;

    typedef struct {
        logic [15:0] data;
        bit          known;
        int          cyc;
    } exp_t;
    exp_t exp_q [$];

    bit mon_en = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                check("missed_beat", cyc, e.cyc);
            end
            if (AddrData_oe) begin
                if (exp_q.size() == 0) begin
                    check("spurious_oe", AddrData_oe, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_cycle", cyc, e.cyc);
                    if (e.known) check("read_data", AddrData_o, e.data);
                end
            end else begin
                check("idle_out", AddrData_o, 0);
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    check("beat_oe", AddrData_oe, 1);
                end
            end
        end
    end

    task automatic do_write(input logic [3:0] pg, input logic [11:0] a, input logic [63:0] d);
        logic [11:0] idx;
        @(posedge clk); #1;
        AddrValid  = 1'b1;
        rw         = 1'b0;
        AddrData_i = {pg, a};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            AddrValid  = 1'b0;
            AddrData_i = d[16*i +: 16];
            if (pg == C_PAGE) begin
                idx        = a + 12'(i);
                model[idx] = d[16*i +: 16];
                known[idx] = 1'b1;
            end
        end
        if (pg == C_PAGE) exp_wr++;
    endtask

    task automatic do_read(input logic [3:0] pg, input logic [11:0] a);
        logic [11:0] idx;
        exp_t        e;
        @(posedge clk); #1;
        AddrValid  = 1'b1;
        rw         = 1'b1;
        AddrData_i = {pg, a};
        if (pg == C_PAGE) begin
            for (int i = 0; i < 4; i++) begin
                idx     = a + 12'(i);
                e.data  = model[idx];
                e.known = known[idx];
                e.cyc   = cyc + 2 + i;
                exp_q.push_back(e);
            end
            exp_rd++;
        end
        @(posedge clk); #1;
        AddrValid  = 1'b0;
        AddrData_i = 16'($urandom);
        repeat (4) @(posedge clk);
    endtask

    task automatic check_stats(input int wr, input int rd);
`ifdef MEMCTRL_STATS_EN
        @(posedge clk); #1;
        check("wr_bursts", wr_bursts, wr);
        check("rd_bursts", rd_bursts, rd);
`else
        @(posedge clk); #1;
        check("stats_absent_oe", AddrData_oe, (wr < 0 || rd < 0) ? 1 : 0);
`endif
    endtask

    initial begin
        logic [3:0]  pg;
        logic [11:0] a;
        logic [63:0] d;
        exp_t        e;
        int          n;

        resetH     = 1'b1;
        AddrValid  = 1'b0;
        rw         = 1'b0;
        AddrData_i = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        resetH = 1'b0;
        @(negedge clk);
        check("reset_oe", AddrData_oe, 0);
        check("reset_out", AddrData_o, 0);
        check_stats(0, 0);
        mon_en = 1'b1;

        // Write then read (back-to-back: read address phase at write N+5).
        do_write(C_PAGE, 12'd32, 64'd128);
        do_read(C_PAGE, 12'd32);

        // Foreign page must neither write nor drive the bus.
        do_write(4'h3, 12'd32, 64'hFFFF_FFFF_FFFF_FFFF);
        do_read(4'h3, 12'd32);
        do_read(C_PAGE, 12'd32);

        // Address wrap at the top of memory.
        do_write(C_PAGE, 12'd0, 64'h0);
        do_write(C_PAGE, 12'd4095, {16'hD, 16'hC, 16'hB, 16'hA});
        do_read(C_PAGE, 12'd4095);
        do_read(C_PAGE, 12'd0);

        // Write aborted by reset during its third data beat.
        do_write(C_PAGE, 12'd100, 64'h0);
        @(posedge clk); #1;
        AddrValid = 1'b1; rw = 1'b0; AddrData_i = {C_PAGE, 12'd100};
        @(posedge clk); #1;
        AddrValid = 1'b0; AddrData_i = 16'h1111;
        model[100] = 16'h1111;
        @(posedge clk); #1;
        AddrData_i = 16'h2222;
        model[101] = 16'h2222;
        @(posedge clk); #1;
        AddrData_i = 16'h3333; resetH = 1'b1;
        @(posedge clk); #1;
        AddrData_i = 16'h4444; resetH = 1'b0;
        exp_wr = 0; exp_rd = 0;
`ifdef MEMCTRL_STATS_EN
        check("abort_wr_bursts", wr_bursts, 0);
`endif
        do_read(C_PAGE, 12'd100);

        // Read aborted by reset after its second beat.
        @(posedge clk); #1;
        AddrValid = 1'b1; rw = 1'b1; AddrData_i = {C_PAGE, 12'd32};
        for (int i = 0; i < 2; i++) begin
            e.data  = model[12'd32 + 12'(i)];
            e.known = known[12'd32 + 12'(i)];
            e.cyc   = cyc + 2 + i;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        AddrValid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetH = 1'b1;
        @(posedge clk); #1;
        resetH = 1'b0;
        exp_wr = 0; exp_rd = 0;
        repeat (2) @(posedge clk);

        // Burst counters.
        do_write(C_PAGE, 12'd200, 64'h0123_4567_89AB_CDEF);
        do_write(C_PAGE, 12'd204, 64'hFEDC_BA98_7654_3210);
        do_write(C_PAGE, 12'd208, 64'h5555_AAAA_5555_AAAA);
        do_read(C_PAGE, 12'd200);
        do_read(C_PAGE, 12'd206);
        check_stats(exp_wr, exp_rd);
        @(posedge clk); #1;
        resetH = 1'b1;
        @(posedge clk); #1;
        resetH = 1'b0;
        exp_wr = 0; exp_rd = 0;
        check_stats(0, 0);

        // Randomised traffic around the wrap point.
        n = 60;
        for (int t = 0; t < n; t++) begin
            pg = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : C_PAGE;
            a  = 12'(4088 + $urandom_range(0, 15));
            d  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) do_write(pg, a, d);
            else                           do_read(pg, a);
        end
        check_stats(exp_wr, exp_rd);

        repeat (8) @(posedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_mem_ctrl
`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Bus-slave memory controller that sits directly downstream of the CPU/processor interface on the main bus. It decodes a multiplexed page/address phase, claims transactions addressed to its configured page and moves one 64-bit value as a 4-beat burst of 16-bit words. Writes go into, and reads come out of, a local 4K×16 synchronous memory array. One instance sits on the bus per memory page.

## Interface
Parameters:
- PAGE, 4'h2, page number this controller responds to.
- ADDR_W, 12, word-address width (memory depth 2^ADDR_W).
- DATA_W, 16, bus/word width.

Ports:
- Clock and reset: one clock, `clk`; reset `resetH`, synchronous and active-high.
- clk  input  1  bus clock; all state changes on rising edge.
- resetH  input  1  synchronous active-high reset.
- AddrValid  input  1  high for exactly one cycle during the address phase.
- rw  input  1  sampled with AddrValid; 1 = read, 0 = write.
- AddrData_i  input  16  address phase {page[3:0], addr[11:0]}; write data beats.
- AddrData_o  output  16  read data beats.
- AddrData_oe  output  1  high only while a read beat is driven.
- wr_bursts  output  16  completed write bursts (only with MEMCTRL_STATS_EN).
- rd_bursts  output  16  completed read bursts (only with MEMCTRL_STATS_EN).

## Operation
- States: IDLE, WRITE, RD_WAIT, READ.
- IDLE: on AddrValid=1 with AddrData_i[15:12]==PAGE, latch base=AddrData_i[11:0] and clear the beat counter (2 bits).
  - rw=0 goes to WRITE; rw=1 goes to RD_WAIT.
  - On a page mismatch, stay in IDLE with no side effects.
- WRITE: each cycle writes AddrData_i to mem[base+beat], where the address is a 12-bit sum that wraps 4095→0. After beat 3, go to IDLE.
- RD_WAIT: one turnaround cycle. Issue the read of mem[base]; AddrData_oe stays 0. Go to READ.
- READ: each cycle drives AddrData_o = mem[base+beat] with AddrData_oe=1 and prefetches the next word. After beat 3, go to IDLE.
- Word order: beat 0 = data[15:0], through beat 3 = data[63:48].
- AddrValid outside IDLE is ignored. The master must not start a new transaction until the burst ends.
- Reset values:
  - state IDLE, beat 0.
  - AddrData_o 16'h0, AddrData_oe 0.
  - counters 0.
  - Memory contents are not reset.
- Reset mid-burst aborts immediately:
  - beats already written persist;
  - beats not yet written are not written;
  - AddrData_oe drops to 0 on the next edge.
- Reset has priority over AddrValid in the same cycle.

## Timing
Address phase is at cycle N.
- Write: data beats at N+1..N+4, each captured on the rising edge ending its cycle. IDLE again at N+5, where a new AddrValid is accepted (back-to-back allowed).
- Read:
  - N+1 is the turnaround cycle (oe=0).
  - Beats are driven during N+2..N+5, with AddrData_oe=1 on exactly those four cycles.
  - IDLE at N+6.
- Read-after-write to the same address, with AddrValid at the write's N+5, returns the new data. There is no bypass path; RAM ordering alone guarantees this.
- AddrData_o returns to 16'h0 whenever AddrData_oe=0.

## Configuration
- MEMCTRL_STATS_EN defined:
  - adds the wr_bursts/rd_bursts ports;
  - each increments on the final beat of a completed burst;
  - saturates at 16'hFFFF;
  - aborted bursts are not counted.
- Undefined: the ports and counters are absent, and the rest of the behaviour is identical.

## Structure
- The shared definitions package holds:
  - the state enum (IDLE, WRITE, RD_WAIT, READ);
  - BURST_LEN=4;
  - the address/data width constants;
  - the unsigned logic typedefs for the 4-bit page, 12-bit address, 16-bit word and 64-bit transfer.
- One sub-module: mem_array, a 2^ADDR_W×DATA_W single-port RAM with write enable and registered read data (1-cycle read latency).
- The FSM, beat counter, page decode and output register live in mem_ctrl.

## Test plan
- Write then read: write page 2, addr 32, data 64'd128, then read the same location. Read beats are 16'h0080, 0, 0, 0 with oe high at N+2..N+5 only.
- Page mismatch: page 3 write of 64'hFFFF_FFFF_FFFF_FFFF to addr 32, then a page 2 read of addr 32. The read returns the prior value; the page 3 transaction never raises AddrData_oe.
- Wrap: page 2 write at addr 4095 of beats 16'hA, 16'hB, 16'hC, 16'hD.
  - A read at 4095 returns A, B, C, D.
  - A read at 0 returns B, C, D, then mem[3].
- Back-to-back: a write burst with AddrValid for a read at N+5 of the same address. The read completes with new data at N+7..N+10.
- Reset mid-burst: resetH asserted at the N+3 edge of a write of 16'h1111, 16'h2222, 16'h3333, 16'h4444 to addr 100 (previously zeroed).
  - A later read returns 16'h1111, 16'h2222, 0, 0.
  - With MEMCTRL_STATS_EN, wr_bursts = 0.
- Stats (MEMCTRL_STATS_EN): 3 writes and 2 reads complete, giving wr_bursts=3 and rd_bursts=2. After resetH, both are 0.
